// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H transmit path.
//   FRAME_SAMPLES / SAMPLE_WIDTH : default frame geometry
//   frame_bytes()                : bytes needed to carry one frame, rounded up
//   bank_idx_t                   : selects one of the two ping-pong banks
package ft2232h_pkg;

   localparam int unsigned FRAME_SAMPLES = 40;
   localparam int unsigned SAMPLE_WIDTH  = 14;

   typedef logic bank_idx_t;

   function automatic int unsigned frame_bytes(input int unsigned width,
                                               input int unsigned samples);
      return (width * samples + 7) / 8;
   endfunction

endpackage

// File: rtl/ft2232h_frame_bank.sv
// One frame buffer: SAMPLES registers of DATA_WIDTH bits, written one slot
// at a time, read as a single flat vector.
//   clk   : write clock
//   we    : write enable for this bank
//   slot  : slot index written when we=1
//   wdata : sample to store
//   data  : flat frame, slot i at [i*DATA_WIDTH +: DATA_WIDTH], MSB first
module ft2232h_frame_bank
   import ft2232h_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
   parameter int unsigned SAMPLES    = FRAME_SAMPLES,
   localparam int unsigned CNT_W     = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [CNT_W-1:0]               slot,
   input  logic [DATA_WIDTH-1:0]          wdata,
   output logic [0:DATA_WIDTH*SAMPLES-1]  data
);

   logic [DATA_WIDTH-1:0] mem [SAMPLES];

   // Sample storage is deliberately not reset; frame_valid gates its use.
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < SAMPLES; i++) begin
         if (we && (slot == CNT_W'(i))) begin
            mem[i] <= wdata;
         end
      end
   end

   // Ascending vector: the sample MSB lands on the lowest index of its field.
   always_comb begin
      data = '0;
      for (int unsigned i = 0; i < SAMPLES; i++) begin
         data[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
      end
   end

endmodule

// File: rtl/ft2232h_frame_packer.sv
// Packs a stream of ADC samples into frames using two ping-pong banks and
// offers each completed frame to the TX stage with a valid/ack handshake.
//   clk, rst_n         : clock, asynchronous active-low reset
//   sample_valid/sample: incoming sample stream
//   sample_ready       : a sample offered this cycle will be stored
//   frame_valid        : frame_data holds a complete frame
//   frame_data         : flat frame, sample i at [i*DATA_WIDTH +: DATA_WIDTH]
//   frame_ack          : one-cycle pulse, current frame consumed
//   overflow           : sticky, at least one sample dropped
//   overflow_clr       : clears overflow and drop_count
//   drop_count         : saturating count of dropped samples
module ft2232h_frame_packer
   import ft2232h_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = SAMPLE_WIDTH,
   parameter int unsigned SAMPLES        = FRAME_SAMPLES,
   parameter int unsigned DROP_CNT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sample_valid,
   input  logic [DATA_WIDTH-1:0]          sample,
   output logic                           sample_ready,
   output logic                           frame_valid,
   output logic [0:DATA_WIDTH*SAMPLES-1]  frame_data,
   input  logic                           frame_ack,
   output logic                           overflow,
   input  logic                           overflow_clr,
   output logic [DROP_CNT_WIDTH-1:0]      drop_count
);

   localparam int unsigned CNT_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
   localparam int unsigned FW    = DATA_WIDTH * SAMPLES;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SAMPLES - 1);

   bank_idx_t        wr_bank;
   bank_idx_t        out_bank;
   logic [CNT_W-1:0] wr_cnt;
   logic [1:0]       full;
   logic [1:0]       full_nxt;
   logic [1:0]       bank_we;
   logic [0:FW-1]    bank_data [2];
   logic             accept;
   logic             drop;
   logic             wr_last;
   logic             release_frame;

   assign sample_ready  = !full[wr_bank];
   assign accept        = sample_valid && sample_ready;
   assign drop          = sample_valid && !sample_ready;
   assign wr_last       = (wr_cnt == LAST_SLOT);
   assign release_frame = frame_valid && frame_ack;
   assign bank_we[0]    = accept && (wr_bank == 1'b0);
   assign bank_we[1]    = accept && (wr_bank == 1'b1);
   assign frame_data    = bank_data[out_bank];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      ft2232h_frame_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .SAMPLES    (SAMPLES)
      ) u_bank (
         .clk   (clk),
         .we    (bank_we[b]),
         .slot  (wr_cnt),
         .wdata (sample),
         .data  (bank_data[b])
      );
   end

   // Completion and release always target different banks (the writer never
   // owns a full bank), so both updates can apply on the same edge.
   always_comb begin
      full_nxt = full;
      if (accept && wr_last) begin
         full_nxt[wr_bank] = 1'b1;
      end
      if (release_frame) begin
         full_nxt[out_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank     <= '0;
         out_bank    <= '0;
         wr_cnt      <= '0;
         full        <= '0;
         frame_valid <= 1'b0;
      end else begin
         full <= full_nxt;
         if (accept) begin
            if (wr_last) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
         // Raising only from frame_valid=0 guarantees a low cycle between frames.
         if (release_frame) begin
            frame_valid <= 1'b0;
            out_bank    <= ~out_bank;
         end else if (!frame_valid && full[out_bank]) begin
            frame_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (overflow_clr) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ft2232h_frame_packer.sv
module tb_ft2232h_frame_packer;
   import ft2232h_pkg::*;

   localparam int W  = SAMPLE_WIDTH;
   localparam int N  = FRAME_SAMPLES;
   localparam int FW = W * N;

   typedef logic [0:FW-1] frame_t;

   typedef struct {
      logic        v;
      logic        clr;
      logic        exp_rdy;
      logic        exp_ovf;
      logic [15:0] exp_dc;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            sample_valid;
   logic [W-1:0]    sample;
   logic            sample_ready;
   logic            frame_valid;
   frame_t          frame_data;
   logic            frame_ack;
   logic            overflow;
   logic            overflow_clr;
   logic [15:0]     drop_count;

   logic            sv2;
   logic [W-1:0]    smp2;
   logic            rdy2;
   logic            fv2;
   logic [0:2*W-1]  fd2;
   logic            ack2;
   logic            ovf2;
   logic            clr2;
   logic [3:0]      dc2;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   frame_t       exp_q[$];
   frame_t       exp_f;
   frame_t       held;
   frame_t       fdc;
   logic         prev_fv = 1'b0;
   logic [W-1:0] cur [N];
   int           cur_n = 0;
   vec_t         tbl [9];

   always #5 clk = ~clk;

   ft2232h_frame_packer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample       (sample),
      .sample_ready (sample_ready),
      .frame_valid  (frame_valid),
      .frame_data   (frame_data),
      .frame_ack    (frame_ack),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .drop_count   (drop_count)
   );

   ft2232h_frame_packer #(
      .DATA_WIDTH     (W),
      .SAMPLES        (2),
      .DROP_CNT_WIDTH (4)
   ) dut_sat (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sv2),
      .sample       (smp2),
      .sample_ready (rdy2),
      .frame_valid  (fv2),
      .frame_data   (fd2),
      .frame_ack    (ack2),
      .overflow     (ovf2),
      .overflow_clr (clr2),
      .drop_count   (dc2)
   );

   function automatic frame_t pack(input logic [W-1:0] s [N]);
      frame_t f;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < W; j++)
            f[i*W + j] = s[i][W-1-j];
      return f;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample (optionally with frame_ack); it must be accepted.
   task automatic feed(input logic [W-1:0] v, input logic ack);
      sample_valid = 1'b1;
      sample       = v;
      frame_ack    = ack;
      check("sample_ready_on_feed", sample_ready, 1'b1);
      cyc();
      sample_valid = 1'b0;
      frame_ack    = 1'b0;
      cur[cur_n] = v;
      cur_n++;
      if (cur_n == N) begin
         exp_q.push_back(pack(cur));
         cur_n = 0;
      end
   endtask

   task automatic ack_once();
      frame_ack = 1'b1;
      cyc();
      frame_ack = 1'b0;
   endtask

   // Frame scoreboard and stability monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_fv = 1'b0;
      end else begin
         if (frame_valid && !prev_fv) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL frame_unexpected: got frame_valid=1 expected no frame");
            end else begin
               exp_f = exp_q.pop_front();
               if (frame_data !== exp_f) begin
                  n_fail++;
                  $display("FAIL frame_data: got %h expected %h", frame_data, exp_f);
               end
            end
            held = frame_data;
         end else if (frame_valid && prev_fv) begin
            n_tests++;
            if (frame_data !== held) begin
               n_fail++;
               $display("FAIL frame_stable: got %h expected %h", frame_data, held);
            end
         end
         prev_fv = frame_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //        v    clr  rdy  ovf  dc
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd2};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd3};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd4};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd5};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0};

      rst_n = 1'b0; sample_valid = 1'b0; sample = '0; frame_ack = 1'b0; overflow_clr = 1'b0;
      sv2 = 1'b0; smp2 = '0; ack2 = 1'b0; clr2 = 1'b0;
      #12;
      check("rst_frame_valid", frame_valid, 1'b0);
      check("rst_sample_ready", sample_ready, 1'b1);
      check("rst_overflow", overflow, 1'b0);
      check("rst_drop_count", drop_count, 16'd0);
      check("rst_sat_drop_count", dc2, 4'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Single frame: sample0 = 2AAA, rest zero.
      for (int i = 0; i < N; i++) feed((i == 0) ? 14'h2AAA : 14'h0, 1'b0);
      check("single_fv_at_t", frame_valid, 1'b0);
      cyc();
      check("single_fv_at_t1", frame_valid, 1'b1);
      fdc = frame_data;
      check("single_fd_0_7", fdc[0:7], 8'hAA);
      check("single_fd_8_15", fdc[8:15], 8'hA8);
      check("single_ready", sample_ready, 1'b1);
      ack_once();
      check("single_fv_after_ack", frame_valid, 1'b0);

      // Ping-pong: 80 samples, ack withheld.
      for (int i = 0; i < 2*N; i++) feed(14'(i), 1'b0);
      check("pp_ready_both_full", sample_ready, 1'b0);
      check("pp_fv_first", frame_valid, 1'b1);
      ack_once();
      check("pp_gap", frame_valid, 1'b0);
      check("pp_ready_after_ack", sample_ready, 1'b1);
      cyc();
      check("pp_second_fv", frame_valid, 1'b1);
      ack_once();

      // Overflow / clear, table driven with both banks full.
      for (int i = 0; i < 2*N; i++) feed(14'(100 + i), 1'b0);
      for (int k = 0; k < 9; k++) begin
         sample_valid = tbl[k].v;
         sample       = 14'h3FFF;
         overflow_clr = tbl[k].clr;
         cyc();
         sample_valid = 1'b0;
         overflow_clr = 1'b0;
         check($sformatf("ovf_tbl%0d_ready", k), sample_ready, tbl[k].exp_rdy);
         check($sformatf("ovf_tbl%0d_overflow", k), overflow, tbl[k].exp_ovf);
         check($sformatf("ovf_tbl%0d_drop_count", k), drop_count, tbl[k].exp_dc);
      end
      // Ack during the low gap must be ignored.
      check("ovf_fv_before_ack", frame_valid, 1'b1);
      ack_once();
      frame_ack = 1'b1;
      cyc();
      frame_ack = 1'b0;
      check("gap_ack_ignored_rise", frame_valid, 1'b1);
      cyc();
      check("gap_ack_ignored_hold", frame_valid, 1'b1);
      ack_once();

      // Bank completion on the same edge as ack of the other bank.
      for (int i = 0; i < 2*N-1; i++) feed(14'(200 + i), 1'b0);
      check("sim_fv_pre", frame_valid, 1'b1);
      feed(14'(200 + 2*N - 1), 1'b1);
      check("sim_fv_gap", frame_valid, 1'b0);
      check("sim_ready_gap", sample_ready, 1'b1);
      cyc();
      check("sim_fv_rise", frame_valid, 1'b1);
      check("sim_ready_rise", sample_ready, 1'b1);
      ack_once();
      check("sim_fv_done", frame_valid, 1'b0);

      // Async reset mid-frame with dirty state everywhere.
      for (int i = 0; i < 2*N; i++) feed(14'(300 + i), 1'b0);
      sample_valid = 1'b1; sample = 14'h1234;
      cyc(); cyc();
      sample_valid = 1'b0;
      check("pre_rst_overflow", overflow, 1'b1);
      check("pre_rst_drop_count", drop_count, 16'd2);
      ack_once();
      cyc();
      check("pre_rst_fv", frame_valid, 1'b1);
      for (int i = 0; i < 17; i++) feed(14'(400 + i), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_fv", frame_valid, 1'b0);
      check("arst_ready", sample_ready, 1'b1);
      check("arst_overflow", overflow, 1'b0);
      check("arst_drop_count", drop_count, 16'd0);
      exp_q.delete();
      cur_n = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int i = 0; i < N; i++) feed(14'((i * 37 + 5) & 14'h3FFF), 1'b0);
      cyc();
      check("post_rst_fv", frame_valid, 1'b1);
      ack_once();
      for (int k = 0; k < 5; k++) begin
         check("post_rst_no_extra", frame_valid, 1'b0);
         cyc();
      end
      check("queue_empty", exp_q.size(), 0);

      // Saturation on the 4-bit counter instance.
      sv2 = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         smp2 = 14'(k);
         cyc();
         if (k == 4) check("sat_ready_full", rdy2, 1'b0);
         if (k > 4) check($sformatf("sat_dc_%0d", k - 4), dc2, (k - 4 > 15) ? 4'd15 : 4'(k - 4));
      end
      sv2 = 1'b0;
      check("sat_overflow", ovf2, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ft2232h_frame_packer.md
Name: ft2232h_frame_packer

Overview:
Upstream stage of the FT2232H synchronous-FIFO transmitter. It collects a continuous stream of DATA_WIDTH-bit ADC samples into frames of SAMPLES samples, using two ping-pong banks. Each completed frame is presented as one flat vector, with a valid/ack handshake, to the byte-serialising TX stage. One bank fills while the other is held stable for TX. Samples that arrive when both banks are occupied are dropped and counted.

Parameters:
DATA_WIDTH, 14, bits per sample
SAMPLES, 40, samples per frame; frame vector width = DATA_WIDTH*SAMPLES
DROP_CNT_WIDTH, 16, width of the saturating dropped-sample counter

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  reset, asynchronous assert, active-low
sample_valid  in  1  sample present this cycle
sample  in  DATA_WIDTH  sample value, MSB = bit DATA_WIDTH-1
sample_ready  out  1  packer can accept a sample this cycle
frame_valid  out  1  frame_data holds a complete frame
frame_data  out  DATA_WIDTH*SAMPLES  ascending range [0:DATA_WIDTH*SAMPLES-1]; sample i at [i*DATA_WIDTH +: DATA_WIDTH], with the sample MSB at the lowest index
frame_ack  in  1  one-cycle pulse from TX: frame consumed, bank may be released
overflow  out  1  sticky: at least one sample dropped
overflow_clr  in  1  clears overflow and drop_count
drop_count  out  DROP_CNT_WIDTH  saturating count of dropped samples

Behaviour:
- Reset (rst_n=0, asynchronous): wr_bank=0, out_bank=0, wr_cnt=0, full[1:0]=0, frame_valid=0, overflow=0, drop_count=0. Bank contents are not reset; frame_data is don't-care while frame_valid=0. Reset mid-frame discards any partial or pending frames.
- sample_ready = !full[wr_bank] (combinational from registers).
- Accept = sample_valid && sample_ready. On accept, write bank[wr_bank] slot wr_cnt <= sample.
  - If wr_cnt == SAMPLES-1: full[wr_bank] <= 1, wr_cnt <= 0, wr_bank toggles.
  - Otherwise wr_cnt increments.
- wr_cnt width = clog2(SAMPLES); wr_cnt never exceeds SAMPLES-1.
- Output side:
  - If frame_valid && frame_ack: frame_valid <= 0, full[out_bank] <= 0, out_bank toggles.
  - Else if !frame_valid && full[out_bank]: frame_valid <= 1.
- A minimum of 1 cycle of frame_valid=0 separates consecutive frames, so TX sees a clean edge.
- Latency: last sample accepted at edge t -> frame_valid=1 after edge t+1, provided the output is idle.
- frame_data = bank[out_bank] via a mux of registered banks. It is stable for the whole frame_valid=1 interval, because the writer never targets a full bank.
- frame_ack while frame_valid=0 is ignored.
- Same-edge events: bank completion and ack of the other bank occur in the same cycle independently; both take effect. A freshly released bank is writable on the next cycle.
- Drop: sample_valid && !sample_ready -> overflow <= 1, drop_count increments and saturates at all-ones. The dropped sample is not stored and wr_cnt is unchanged.
- overflow_clr has priority over a simultaneous drop: both cleared, that drop not counted.
- Bank ordering is strictly alternating, so out_bank always selects the oldest full bank.

Decomposition:
- Shared package ft2232h_pkg:
  - FRAME_SAMPLES=40 and SAMPLE_WIDTH=14 constants.
  - Function frame_bytes(width, samples) = ceil(width*samples/8), shared with the TX stage.
  - bank-index typedef.
- One sub-module, ft2232h_frame_bank:
  - a SAMPLES x DATA_WIDTH register bank with write enable and slot index.
  - exposes the flat [0:N-1] vector.
  - instantiated twice.

Test Plan:
- Single frame (defaults): after reset, feed 40 samples, sample0=14'h2AAA and others 0, no stalls -> frame_valid rises 1 cycle after the 40th accept; frame_data[0:7]=8'hAA and [8:15]=8'hA8; sample_ready stays 1.
- Ping-pong: feed 80 consecutive samples valued 0..79 with ack withheld:
  - frame 1 holds 0..39 stable throughout.
  - sample_ready=0 after the 80th accept.
  - ack -> frame_valid low 1 cycle, then high with 40..79.
- Overflow: with both banks full, drive sample_valid for 5 cycles -> overflow=1, drop_count=5. Pulse overflow_clr alongside a 6th drop -> overflow=0, drop_count=0.
- Saturation: DROP_CNT_WIDTH=4, 20 drops -> drop_count=15.
- Simultaneous events: complete bank 1 on the same edge as the ack of bank 0 -> next cycle frame_valid=0; the following cycle frame_valid=1 with bank 1 data; sample_ready=1 throughout.
- Async reset mid-frame after 17 samples -> all outputs reset immediately without a clock edge. Then 40 new samples -> a single correct frame with no stale data.
